// File: rtl/gaussian3x3_stream_if.sv
// Valid/ready pixel stream bundle shared by the blur input and output.
// The master drives data, valid and last; the slave returns ready.
interface gaussian3x3_stream_if #(
    parameter int PIXEL_BIT_WIDTH = 16
);
    logic [PIXEL_BIT_WIDTH-1:0] TDATA;
    logic                       TVALID;
    logic                       TREADY;
    logic                       TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/gaussian3x3_stream.sv
// Streaming 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16) over a raster pixel stream.
// Two line buffers feed a 3-column window; one registered output stage.
//
//   state | meaning
//   FILL  | rows 0 and 1 being buffered, nothing emitted
//   RUN   | row_in >= 2, handshakes at col_in >= 2 emit one pixel
module gaussian3x3_stream #(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int IMG_ROWS         = 48,
    parameter int IMG_COLS         = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    gaussian3x3_stream_if.slave   pixel_in,
    gaussian3x3_stream_if.master  pixel_out
);
    localparam int PW     = PIXEL_BIT_WIDTH;
    localparam int ACC_W  = PIXEL_BIT_WIDTH + 4;
    localparam int CIDX_W = $clog2(IMG_COLS);
    localparam logic [IMG_ROW_BITWIDTH-1:0] LAST_ROW = IMG_ROW_BITWIDTH'(IMG_ROWS - 1);
    localparam logic [IMG_COL_BITWIDTH-1:0] LAST_COL = IMG_COL_BITWIDTH'(IMG_COLS - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t                      state;
    logic [IMG_ROW_BITWIDTH-1:0] row_in;
    logic [IMG_COL_BITWIDTH-1:0] col_in;
    logic [CIDX_W-1:0]           col_idx;

    logic [PW-1:0] lb0 [IMG_COLS];
    logic [PW-1:0] lb1 [IMG_COLS];

    // l_* is column c-2, m_* is column c-1; top/mid/bot are rows r-2/r-1/r
    logic [PW-1:0] l_top, l_mid, l_bot, m_top, m_mid, m_bot;
    logic [PW-1:0] n_top, n_mid, n_bot;

    logic                    out_valid;
    logic [PW-1:0]           out_data;
    logic                    out_last;
    logic                    in_ready;
    logic                    in_hs;
    logic                    row_end;
    logic                    frame_end;
    logic                    emit;
    logic signed [ACC_W-1:0] acc;
    logic [PW-1:0]           blur;

    function automatic logic signed [ACC_W-1:0] sx(input logic [PW-1:0] p);
        return ACC_W'(signed'(p));
    endfunction

    assign in_ready  = reset & (~out_valid | pixel_out.TREADY);
    assign in_hs     = pixel_in.TVALID & in_ready;
    assign col_idx   = col_in[CIDX_W-1:0];
    assign row_end   = (col_in == LAST_COL);
    assign frame_end = row_end && (row_in == LAST_ROW);
    assign emit      = in_hs && (state == RUN) && (col_in >= IMG_COL_BITWIDTH'(2));

    assign n_top = lb1[col_idx];
    assign n_mid = lb0[col_idx];
    assign n_bot = pixel_in.TDATA;

    // Weights of 2 and 4 are shifts; the sum of weights is 16 so ACC_W cannot overflow
    assign acc = sx(l_top)         + (sx(l_mid) <<< 1) + sx(l_bot)
               + (sx(m_top) <<< 1) + (sx(m_mid) <<< 2) + (sx(m_bot) <<< 1)
               + sx(n_top)         + (sx(n_mid) <<< 1) + sx(n_bot);
    assign blur = PW'(acc >>> 4);

    assign pixel_in.TREADY  = in_ready;
    assign pixel_out.TVALID = out_valid;
    assign pixel_out.TDATA  = out_data;
    assign pixel_out.TLAST  = out_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= FILL;
            row_in    <= '0;
            col_in    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (in_hs) begin
                if (frame_end) begin
                    row_in <= '0;
                    col_in <= '0;
                end else if (row_end) begin
                    row_in <= row_in + 1'b1;
                    col_in <= '0;
                end else begin
                    col_in <= col_in + 1'b1;
                end

                case (state)
                    FILL: if (row_end && row_in == IMG_ROW_BITWIDTH'(1)) state <= RUN;
                    RUN:  if (frame_end) state <= FILL;
                    default: state <= FILL;
                endcase
            end

            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= blur;
                out_last  <= frame_end;
            end else if (pixel_out.TREADY) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Line buffers and window carry no reset; stale columns are never emitted
    always_ff @(posedge clk) begin
        if (in_hs) begin
            lb1[col_idx] <= lb0[col_idx];
            lb0[col_idx] <= pixel_in.TDATA;
            l_top <= m_top;
            l_mid <= m_mid;
            l_bot <= m_bot;
            m_top <= n_top;
            m_mid <= n_mid;
            m_bot <= n_bot;
        end
    end
endmodule

// File: tb/tb_gaussian3x3_stream.sv
// Scoreboard bench for gaussian3x3_stream: directed frames push expected pixels,
// an independent monitor pops and compares on every output handshake.
module tb_gaussian3x3_stream;
    localparam int R    = 48;
    localparam int C    = 48;
    localparam int NOUT = (R - 2) * (C - 2);

    localparam int M_RAMP  = 0;
    localparam int M_IMP16 = 1;
    localparam int M_CONST = 2;
    localparam int M_IMPP1 = 3;
    localparam int M_IMPM1 = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   out_cnt = 0;
    int   tlast_cnt = 0;
    int   cyc = 0;
    int   hs22_cyc = -1;
    int   first_vcyc = -1;
    bit   note_hs = 0;
    bit   first_arm = 0;
    bit   rand_ready = 0;
    bit   stall_req = 0;

    logic clk = 0;
    logic reset;

    gaussian3x3_stream_if #(.PIXEL_BIT_WIDTH(16)) pixel_in_bus ();
    gaussian3x3_stream_if #(.PIXEL_BIT_WIDTH(16)) pixel_out_bus ();

    gaussian3x3_stream #(
        .PIXEL_BIT_WIDTH (16),
        .IMG_ROWS        (R),
        .IMG_COLS        (C),
        .IMG_ROW_BITWIDTH(10),
        .IMG_COL_BITWIDTH(10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pixel_in (pixel_in_bus),
        .pixel_out(pixel_out_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pix(input int mode, input int r, input int c);
        bit hit;
        hit = (r == 10 && c == 10);
        case (mode)
            M_RAMP:  return 16'(r * C + c);
            M_IMP16: return hit ? 16'd16 : 16'd0;
            M_CONST: return 16'hFFFD;
            M_IMPP1: return hit ? 16'd1 : 16'd0;
            default: return hit ? 16'hFFFF : 16'd0;
        endcase
    endfunction

    // Expected output (i,j) is centred on input (i+1,j+1)
    function automatic logic [15:0] expv(input int mode, input int i, input int j);
        int amp, di, dj, w;
        if (mode == M_RAMP)  return 16'((i + 1) * C + (j + 1));
        if (mode == M_CONST) return 16'hFFFD;
        amp = (mode == M_IMP16) ? 16 : (mode == M_IMPP1) ? 1 : -1;
        di = i + 1 - 10;
        dj = j + 1 - 10;
        if (di < -1 || di > 1 || dj < -1 || dj > 1) return 16'd0;
        w = (2 - (di < 0 ? -di : di)) * (2 - (dj < 0 ? -dj : dj));
        return 16'((amp * w) >>> 4);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic send_pixels(input int mode, input int npix, input bit rand_valid);
        for (int k = 0; k < npix; k++) begin
            int   r;
            int   c;
            int   guard;
            int   snap;
            bit   hs;
            exp_t e;
            r = k / C;
            c = k % C;
            if (rand_valid) begin
                while ($urandom_range(0, 3) == 0) begin
                    pixel_in_bus.TVALID = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            pixel_in_bus.TDATA  = pix(mode, r, c);
            pixel_in_bus.TVALID = 1'b1;
            if (r >= 2 && c >= 2) begin
                e.data = expv(mode, r - 2, c - 2);
                e.last = (r == R - 1 && c == C - 1);
                sb.push_back(e);
            end
            guard = 0;
            snap  = 0;
            forever begin
                @(negedge clk);
                hs   = pixel_in_bus.TREADY;
                snap = cyc;
                @(posedge clk);
                #1;
                if (hs) break;
                guard++;
                if (guard > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL input_timeout: pixel %0d not accepted, expected acceptance", k);
                    break;
                end
            end
            if (note_hs && k == 2 * C + 2) hs22_cyc = snap;
        end
        pixel_in_bus.TVALID = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || pixel_out_bus.TVALID === 1'b1) && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({name, "_drain_pending"}, sb.size(), 0);
    endtask

    // Output sink: fixed, stalled or random ready
    initial begin
        pixel_out_bus.TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) pixel_out_bus.TREADY = ($urandom_range(0, 2) != 0);
            else            pixel_out_bus.TREADY = !stall_req;
        end
    end

    // Monitor: handshake completes at the next rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (first_arm && pixel_out_bus.TVALID === 1'b1) begin
                first_vcyc = cyc;
                first_arm  = 0;
            end
            if (pixel_out_bus.TVALID === 1'b1 && pixel_out_bus.TREADY === 1'b1) begin
                out_cnt++;
                if (pixel_out_bus.TLAST === 1'b1) tlast_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got data %0d, expected no output",
                             $signed(pixel_out_bus.TDATA));
                end else begin
                    e = sb.pop_front();
                    if (pixel_out_bus.TDATA !== e.data || pixel_out_bus.TLAST !== e.last) begin
                        errors++;
                        $display("FAIL out_pixel %0d: got data %0d last %0b, expected data %0d last %0b",
                                 out_cnt, $signed(pixel_out_bus.TDATA), pixel_out_bus.TLAST,
                                 $signed(e.data), e.last);
                    end
                end
            end
        end
    end

    initial begin
        int base_out;
        int base_last;
        logic [15:0] hold;

        reset = 1'b0;
        pixel_in_bus.TVALID = 1'b0;
        pixel_in_bus.TDATA  = '0;
        pixel_in_bus.TLAST  = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(pixel_out_bus.TVALID), 0);
        check("rst_out_data",  int'(pixel_out_bus.TDATA), 0);
        check("rst_out_last",  int'(pixel_out_bus.TLAST), 0);
        check("rst_in_ready",  int'(pixel_in_bus.TREADY), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_valid", int'(pixel_out_bus.TVALID), 0);
        check("post_rst_in_ready", int'(pixel_in_bus.TREADY), 1);

        // Ramp with latency check
        @(posedge clk);
        #1;
        note_hs = 1;
        first_arm = 1;
        send_pixels(M_RAMP, R * C, 0);
        note_hs = 0;
        wait_drain("ramp");
        check("ramp_count", out_cnt, NOUT);
        check("ramp_tlast", tlast_cnt, 1);
        check("ramp_latency", first_vcyc - hs22_cyc, 1);

        // Impulse and sign/floor patterns
        send_pixels(M_IMP16, R * C, 0);
        wait_drain("impulse16");
        send_pixels(M_CONST, R * C, 0);
        wait_drain("const_m3");
        send_pixels(M_IMPP1, R * C, 0);
        wait_drain("impulse_p1");
        send_pixels(M_IMPM1, R * C, 0);
        wait_drain("impulse_m1");
        check("patterns_count", out_cnt, 5 * NOUT);

        // Backpressure: 100-cycle stall mid-frame
        fork
            send_pixels(M_RAMP, R * C, 0);
            begin
                repeat (700) @(posedge clk);
                #1;
                stall_req = 1;
                for (int g = 0; g < 20; g++) begin
                    @(negedge clk);
                    if (pixel_out_bus.TVALID === 1'b1 && pixel_out_bus.TREADY === 1'b0) break;
                end
                check("stall_engaged", int'(pixel_out_bus.TVALID && !pixel_out_bus.TREADY), 1);
                hold = pixel_out_bus.TDATA;
                for (int s = 0; s < 100; s++) begin
                    @(negedge clk);
                    check("stall_in_ready", int'(pixel_in_bus.TREADY), 0);
                    check("stall_data_hold", int'(pixel_out_bus.TDATA), int'(hold));
                end
                @(posedge clk);
                #1;
                stall_req = 0;
            end
        join
        wait_drain("stall");

        // Randomised valid and ready
        rand_ready = 1;
        send_pixels(M_RAMP, R * C, 1);
        wait_drain("random");
        rand_ready = 0;
        check("random_count", out_cnt, 7 * NOUT);

        // Reset mid-frame after 1000 inputs
        send_pixels(M_RAMP, 1000, 0);
        wait_drain("partial");
        base_out = out_cnt;
        base_last = tlast_cnt;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", int'(pixel_in_bus.TREADY), 0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", int'(pixel_out_bus.TVALID), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_post_valid", int'(pixel_out_bus.TVALID), 0);
        sb.delete();
        @(posedge clk);
        #1;
        send_pixels(M_RAMP, R * C, 0);
        wait_drain("after_reset");
        check("after_reset_count", out_cnt - base_out, NOUT);
        check("after_reset_tlast", tlast_cnt - base_last, 1);

        // Three back-to-back frames
        base_out = out_cnt;
        base_last = tlast_cnt;
        for (int f = 0; f < 3; f++) send_pixels(M_RAMP, R * C, 0);
        wait_drain("b2b");
        check("b2b_count", out_cnt - base_out, 3 * NOUT);
        check("b2b_tlast", tlast_cnt - base_last, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
